mem_access_arbiter: RTL and testbench

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: two-requester round-robin memory arbiter with
// virtual-to-physical translation of a data region and a stack region.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   r0_* / r1_*           requester ports (req, we, vaddr, wdata, ack)
//   rdata, fault          result of the last completed access
//   mem_en, mem_we        memory strobes (only in ACCESS, never on fault)
//   mem_addr, mem_wdata   physical word address and write data
//   mem_rdata             combinational read data from mem_addr
//   gnt0_cnt, gnt1_cnt,   saturating grant/fault counters, present only
//   fault_cnt             when MEM_ARB_STATS_EN is defined
//
// Build option: define MEM_ARB_STATS_EN to add the statistics counters.

module mem_access_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [31:0] r0_vaddr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [31:0] r1_vaddr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        mem_en,
    output logic        mem_we,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] gnt0_cnt,
    output logic [15:0] gnt1_cnt,
    output logic [15:0] fault_cnt
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  r_state;
    logic        r_last_gnt1;  // 1: requester 1 owned the previous grant
    logic        r_gnt1;
    logic        r_we;
    logic        r_xfault;
    logic [10:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_any;
    logic        w_gnt1;
    logic        w_we;
    logic [31:0] w_vaddr;
    logic [31:0] w_wdata;
    logic        w_in_data;
    logic        w_in_stack;
    logic        w_xfault;
    logic [10:0] w_xaddr;
    logic        w_access;
    logic        w_resp;

    // Tie goes to whoever did not win last; a lone requester always wins.
    assign w_any   = r0_req | r1_req;
    assign w_gnt1  = r1_req & (~r0_req | ~r_last_gnt1);
    assign w_we    = w_gnt1 ? r1_we    : r0_we;
    assign w_vaddr = w_gnt1 ? r1_vaddr : r0_vaddr;
    assign w_wdata = w_gnt1 ? r1_wdata : r0_wdata;

    // Both regions are 4 KiB aligned, so a page-number compare suffices;
    // the stack region lands in the upper half of the physical words.
    assign w_in_data  = (w_vaddr[31:12] == 20'h10010);
    assign w_in_stack = (w_vaddr[31:12] == 20'h7FFFE);
    assign w_xfault   = ~(w_in_data | w_in_stack) | (w_vaddr[1:0] != 2'b00);
    assign w_xaddr    = {w_in_stack, w_vaddr[11:2]};

    assign w_access = (r_state == S_ACCESS) & ~r_xfault;
    assign w_resp   = (r_state == S_RESP);

    assign mem_en    = w_access;
    assign mem_we    = w_access & r_we;
    assign mem_addr  = w_access ? r_addr : 11'd0;
    assign mem_wdata = (w_access & r_we) ? r_wdata : 32'd0;

    assign r0_ack = w_resp & ~r_gnt1;
    assign r1_ack = w_resp & r_gnt1;
    assign rdata  = r_rdata;
    assign fault  = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_gnt1 <= 1'b1;
            r_gnt1      <= 1'b0;
            r_we        <= 1'b0;
            r_xfault    <= 1'b0;
            r_addr      <= 11'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt1      <= w_gnt1;
                        r_last_gnt1 <= w_gnt1;
                        r_we        <= w_we;
                        r_xfault    <= w_xfault;
                        r_addr      <= w_xaddr;
                        r_wdata     <= w_wdata;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_rdata <= (r_we | r_xfault) ? 32'd0 : mem_rdata;
                    r_fault <= r_xfault;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_gnt0_cnt;
    logic [15:0] r_gnt1_cnt;
    logic [15:0] r_fault_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt0_cnt  <= 16'd0;
            r_gnt1_cnt  <= 16'd0;
            r_fault_cnt <= 16'd0;
        end else if (w_resp) begin
            if (!r_gnt1 && r_gnt0_cnt != 16'hFFFF)
                r_gnt0_cnt <= r_gnt0_cnt + 16'd1;
            if (r_gnt1 && r_gnt1_cnt != 16'hFFFF)
                r_gnt1_cnt <= r_gnt1_cnt + 16'd1;
            if (r_fault && r_fault_cnt != 16'hFFFF)
                r_fault_cnt <= r_fault_cnt + 16'd1;
        end
    end

    assign gnt0_cnt  = r_gnt0_cnt;
    assign gnt1_cnt  = r_gnt1_cnt;
    assign fault_cnt = r_fault_cnt;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter: vector table, hand-written corner sequences and
// randomized traffic against a transaction-level reference model.

module tb_mem_access_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_req, r0_we, r0_ack;
    logic [31:0] r0_vaddr, r0_wdata;
    logic        r1_req, r1_we, r1_ack;
    logic [31:0] r1_vaddr, r1_wdata;
    logic [31:0] rdata;
    logic        fault;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] gnt0_cnt, gnt1_cnt, fault_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem  [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic        mem_init;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_vaddr(r0_vaddr),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_vaddr(r1_vaddr),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rdata(rdata), .fault(fault),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .fault_cnt(fault_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 2047) return 32'h12345678;
        return 32'hA5000000 + 32'(i) * 32'h00010001;
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) tb_mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = tb_mem[mem_addr];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns {fault, word address} from the address map rules.
    function automatic logic [11:0] xlate(input logic [31:0] va);
        if (va % 4 != 0) return {1'b1, 11'd0};
        if (va >= 32'h10010000 && va <= 32'h10010FFC)
            return {1'b0, 11'((va - 32'h10010000) / 4)};
        if (va >= 32'h7FFFE000 && va <= 32'h7FFFEFFC)
            return {1'b0, 11'(1024 + (va - 32'h7FFFE000) / 4)};
        return {1'b1, 11'd0};
    endfunction

    function automatic logic [31:0] rand_vaddr();
        int k;
        logic [31:0] w;
        k = $urandom_range(0, 9);
        w = 32'($urandom_range(0, 15)) * 4;
        case (k)
            0, 1, 2: return 32'h10010000 + w;
            3:       return 32'h10010FC0 + w;
            4, 5:    return 32'h7FFFE000 + w;
            6:       return 32'h7FFFEFC0 + w;
            7:       return 32'h10010000 + w + 32'($urandom_range(1, 3));
            8:       return 32'h10011000 + w;
            default: return $urandom();
        endcase
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mem_init = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_vaddr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_vaddr = '0; r1_wdata = '0;
        @(negedge clk);
        mem_init = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input logic who, input logic we,
                         input logic [31:0] va, input logic [31:0] wd);
        r0_req = !who; r1_req = who;
        if (who) begin r1_we = we; r1_vaddr = va; r1_wdata = wd; end
        else     begin r0_we = we; r0_vaddr = va; r0_wdata = wd; end
    endtask

    typedef struct {
        logic        who;
        logic        we;
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic        efault;
        logic [10:0] eaddr;
        logic [31:0] erdata;
    } vec_t;

    // Entered at a negedge in IDLE: accept at T, ACCESS at T+1, ack at T+2.
    task automatic run_vec(input vec_t v, input int n);
        drive(v.who, v.we, v.vaddr, v.wdata);
        @(negedge clk);
        chk($sformatf("v%0d_mem_en", n), mem_en, !v.efault);
        chk($sformatf("v%0d_mem_we", n), mem_we, v.we & !v.efault);
        if (!v.efault)
            chk($sformatf("v%0d_mem_addr", n), mem_addr, v.eaddr);
        if (v.we && !v.efault)
            chk($sformatf("v%0d_mem_wdata", n), mem_wdata, v.wdata);
        chk($sformatf("v%0d_ack_early", n), {r1_ack, r0_ack}, 2'b00);
        @(negedge clk);
        chk($sformatf("v%0d_ack", n), {r1_ack, r0_ack},
            v.who ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_fault", n), fault, v.efault);
        chk($sformatf("v%0d_rdata", n), rdata, v.erdata);
        chk($sformatf("v%0d_resp_en", n), {mem_en, mem_we}, 2'b00);
        r0_req = 1'b0; r1_req = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ack_idle", n), {r1_ack, r0_ack}, 2'b00);
    endtask

    vec_t vt [15];

    // random-phase model state
    bit          infl, act0, act1, last_gnt, m_who, m_we, m_fault, who;
    logic [10:0] m_addr;
    logic [31:0] m_wdata, e_rdata;
    logic        e_fault;
    int          t_acc, last_resp;

    initial begin
        rst = 1'b1; mem_init = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_vaddr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_vaddr = '0; r1_wdata = '0;

        vt[0]  = '{0, 1, 32'h10010008, 32'hDEADBEEF, 0, 11'd2,    32'h0};
        vt[1]  = '{1, 0, 32'h7FFFEFFC, 32'h0,        0, 11'd2047, 32'h12345678};
        vt[2]  = '{0, 0, 32'h10011000, 32'h0,        1, 11'd0,    32'h0};
        vt[3]  = '{0, 0, 32'h10010002, 32'h0,        1, 11'd0,    32'h0};
        vt[4]  = '{1, 0, 32'h10010008, 32'h0,        0, 11'd2,    32'hDEADBEEF};
        vt[5]  = '{0, 1, 32'h10010000, 32'hCAFEF00D, 0, 11'd0,    32'h0};
        vt[6]  = '{0, 0, 32'h10010000, 32'h0,        0, 11'd0,    32'hCAFEF00D};
        vt[7]  = '{1, 1, 32'h7FFFE000, 32'h01234567, 0, 11'd1024, 32'h0};
        vt[8]  = '{1, 0, 32'h7FFFE000, 32'h0,        0, 11'd1024, 32'h01234567};
        vt[9]  = '{0, 1, 32'h10010FFC, 32'hA5A5A5A5, 0, 11'd1023, 32'h0};
        vt[10] = '{1, 0, 32'h10010FFC, 32'h0,        0, 11'd1023, 32'hA5A5A5A5};
        vt[11] = '{0, 1, 32'h7FFFF000, 32'h55555555, 1, 11'd0,    32'h0};
        vt[12] = '{1, 1, 32'h1000FFFC, 32'h66666666, 1, 11'd0,    32'h0};
        vt[13] = '{0, 0, 32'h7FFFDFFC, 32'h0,        1, 11'd0,    32'h0};
        vt[14] = '{1, 1, 32'h7FFFE001, 32'h77777777, 1, 11'd0,    32'h0};

        // reset state
        do_reset();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_acks", {r1_ack, r0_ack}, 2'b00);
        chk("rst_mem_en_we", {mem_en, mem_we}, 2'b00);
        chk("rst_mem_addr", mem_addr, 11'd0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);

        for (int i = 0; i < 15; i++) run_vec(vt[i], i);

        // both held from reset: r0 wins first, then strict alternation
        @(negedge clk);
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 1'b0; r0_vaddr = 32'h10010010;
        r1_req = 1'b1; r1_we = 1'b0; r1_vaddr = 32'h7FFFE010;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 13; c++) begin
            logic [1:0] e;
            e = (c == 2 || c == 8) ? 2'b01 :
                (c == 5 || c == 11) ? 2'b10 : 2'b00;
            chk($sformatf("rr_ack_c%0d", c), {r1_ack, r0_ack}, e);
            @(negedge clk);
        end

        // reset during the ACCESS cycle of an r0 write
        do_reset();
        drive(1'b0, 1'b1, 32'h10010020, 32'h11111111);
        @(negedge clk);
        chk("abort_pre_we", mem_we, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem", {mem_en, mem_we}, 2'b00);
        chk("abort_ack", {r1_ack, r0_ack}, 2'b00);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_fault", fault, 1'b0);
        rst = 1'b0; r0_req = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort_noack%0d", c), {r1_ack, r0_ack, mem_we},
                3'b000);
        end
        r0_req = 1'b1; r0_we = 1'b0; r0_vaddr = 32'h10010020;
        r1_req = 1'b1; r1_we = 1'b0; r1_vaddr = 32'h7FFFE004;
        @(negedge clk);
        @(negedge clk);
        chk("abort_next_gnt", {r1_ack, r0_ack}, 2'b01);
        r0_req = 1'b0; r1_req = 1'b0;
        @(negedge clk);

`ifdef MEM_ARB_STATS_EN
        do_reset();
        chk("stat_rst", {gnt0_cnt, gnt1_cnt}, 32'h0);
        run_vec('{0, 1, 32'h10010040, 32'h1, 0, 11'd16, 32'h0}, 100);
        run_vec('{0, 0, 32'h10010041, 32'h0, 1, 11'd0, 32'h0}, 101);
        run_vec('{1, 0, 32'h10010040, 32'h0, 0, 11'd16, 32'h1}, 102);
        run_vec('{0, 0, 32'h10010040, 32'h0, 0, 11'd16, 32'h1}, 103);
        run_vec('{1, 1, 32'h7FFFE040, 32'h2, 0, 11'd1040, 32'h0}, 104);
        chk("stat_gnt0", gnt0_cnt, 16'd3);
        chk("stat_gnt1", gnt1_cnt, 16'd2);
        chk("stat_fault", fault_cnt, 16'd1);
`endif

        // randomized traffic vs transaction-level model
        do_reset();
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_word(i);
        infl = 0; act0 = 0; act1 = 0; last_gnt = 1;
        e_rdata = 32'h0; e_fault = 1'b0;
        t_acc = -10; last_resp = -1;
        m_who = 0; m_we = 0; m_fault = 0; m_addr = '0; m_wdata = '0;
        for (int c = 0; c < 800; c++) begin
            if (infl && c == t_acc + 1) begin
                chk("rnd_mem_en", mem_en, !m_fault);
                chk("rnd_mem_we", mem_we, m_we & !m_fault);
                if (!m_fault) chk("rnd_mem_addr", mem_addr, m_addr);
                if (m_we && !m_fault) begin
                    chk("rnd_mem_wdata", mem_wdata, m_wdata);
                    ref_mem[m_addr] = m_wdata;
                end
            end else begin
                chk("rnd_mem_idle", {mem_en, mem_we}, 2'b00);
            end
            if (infl && c == t_acc + 2) begin
                e_rdata = (m_we || m_fault) ? 32'h0 : ref_mem[m_addr];
                e_fault = m_fault;
                chk("rnd_ack", {r1_ack, r0_ack}, m_who ? 2'b10 : 2'b01);
                infl = 0; last_resp = c;
                if (m_who) act1 = 0; else act0 = 0;
            end else begin
                chk("rnd_noack", {r1_ack, r0_ack}, 2'b00);
            end
            chk("rnd_rdata", rdata, e_rdata);
            chk("rnd_fault", fault, e_fault);

            if (!act0) begin
                act0 = $urandom_range(0, 1) == 1;
                r0_req = act0; r0_we = $urandom_range(0, 1) == 1;
                r0_vaddr = rand_vaddr(); r0_wdata = $urandom();
            end
            if (!act1) begin
                act1 = $urandom_range(0, 1) == 1;
                r1_req = act1; r1_we = $urandom_range(0, 1) == 1;
                r1_vaddr = rand_vaddr(); r1_wdata = $urandom();
            end

            if (!infl && c > last_resp && (r0_req || r1_req)) begin
                who = (r0_req && r1_req) ? !last_gnt : r1_req;
                last_gnt = who; m_who = who; infl = 1; t_acc = c;
                m_we = who ? r1_we : r0_we;
                m_wdata = who ? r1_wdata : r0_wdata;
                {m_fault, m_addr} = xlate(who ? r1_vaddr : r0_vaddr);
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
